// File: rtl/sp_host.sv
// rtl/sp_host.sv - initiator-side frame source/sink for the SP core
//
// Purpose: buffers one frame of DEPTH 9-bit samples from a local loader,
// streams it to SP as a contiguous in_valid burst (mode on beat 0), then
// collects the DEPTH-beat out_valid response into a readable RX buffer.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   ld_valid, ld_data             TX buffer load (IDLE only, wraps at DEPTH)
//   start, start_mode, start_cg   frame launch (IDLE only)
//   busy, done, err               status: not-idle, completion pulse, sticky error
//   rd_addr, rd_data              RX buffer read port (combinational)
//   cg_en, in_valid, in_data,
//   in_mode                       registered outputs to SP
//   out_valid, out_data           response from SP
//
// Build option: SP_HOST_TIMEOUT_EN adds a WAIT-state timeout of TIMEOUT cycles.

module sp_host #(
    parameter int DEPTH   = 6,
    parameter int TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld_valid,
    input  logic [8:0] ld_data,
    input  logic       start,
    input  logic [2:0] start_mode,
    input  logic       start_cg,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       cg_en,
    output logic       in_valid,
    output logic [8:0] in_data,
    output logic [2:0] in_mode,
    input  logic       out_valid,
    input  logic [8:0] out_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST = 4'(DEPTH - 1);

    state_t     state_q, state_d;
    logic [3:0] wptr_q, wptr_d;
    logic [3:0] tx_cnt_q, tx_cnt_d;
    logic [3:0] rx_cnt_q, rx_cnt_d;
    logic [2:0] mode_q, mode_d;
    logic       cg_en_q, cg_en_d;
    logic       err_q, err_d;
    logic       in_valid_q, in_valid_d;
    logic [8:0] in_data_q, in_data_d;
    logic [2:0] in_mode_q, in_mode_d;

    // Buffers are sized to the full 4-bit index space so every index is in
    // range; entries at or above DEPTH are never written and stay zero.
    logic [8:0] tx_buf_q [16];
    logic [8:0] tx_buf_d [16];
    logic [8:0] rx_buf_q [16];
    logic [8:0] rx_buf_d [16];

`ifdef SP_HOST_TIMEOUT_EN
    localparam int             TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  WAIT_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
`else
    // No counter in this build; TIMEOUT is only sanity-checked.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        mode_d   = mode_q;
        cg_en_d  = cg_en_q;
        err_d    = err_q;
        tx_buf_d = tx_buf_q;
        rx_buf_d = rx_buf_q;
`ifdef SP_HOST_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                // Load is applied before start so a same-cycle load is in the burst.
                if (ld_valid) begin
                    tx_buf_d[wptr_q] = ld_data;
                    wptr_d = (wptr_q == LAST) ? 4'd0 : wptr_q + 4'd1;
                end
                if (start) begin
                    mode_d   = start_mode;
                    cg_en_d  = start_cg;
                    err_d    = 1'b0;
                    tx_cnt_d = 4'd0;
                    rx_cnt_d = 4'd0;
                    state_d  = S_SEND;
                end
                if (out_valid) begin
                    err_d = 1'b1;
                end
            end
            S_SEND: begin
                if (out_valid) begin
                    err_d = 1'b1;
                end
                if (tx_cnt_q == LAST) begin
                    state_d = S_WAIT;
`ifdef SP_HOST_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end else begin
                    tx_cnt_d = tx_cnt_q + 4'd1;
                end
            end
            S_WAIT: begin
                if (out_valid) begin
                    rx_buf_d[0] = out_data;
                    rx_cnt_d    = 4'd1;
                    state_d     = S_RECV;
                end
`ifdef SP_HOST_TIMEOUT_EN
                else if (wait_cnt_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            S_RECV: begin
                if (out_valid) begin
                    rx_buf_d[rx_cnt_q] = out_data;
                    if (rx_cnt_q == LAST) begin
                        state_d = S_DONE;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 4'd1;
                    end
                end else begin
                    // Response burst broke before the frame was complete.
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                wptr_d  = 4'd0;
                if (out_valid) begin
                    err_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // SP-side outputs are computed from next-state values so they can be
        // registered yet still line up with the state they describe.
        in_valid_d = (state_d == S_SEND);
        in_data_d  = in_valid_d ? tx_buf_d[tx_cnt_d] : 9'd0;
        in_mode_d  = (in_valid_d && (tx_cnt_d == 4'd0)) ? mode_d : 3'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wptr_q     <= 4'd0;
            tx_cnt_q   <= 4'd0;
            rx_cnt_q   <= 4'd0;
            mode_q     <= 3'd0;
            cg_en_q    <= 1'b0;
            err_q      <= 1'b0;
            in_valid_q <= 1'b0;
            in_data_q  <= 9'd0;
            in_mode_q  <= 3'd0;
            for (int i = 0; i < 16; i++) begin
                tx_buf_q[i] <= 9'd0;
                rx_buf_q[i] <= 9'd0;
            end
`ifdef SP_HOST_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            mode_q     <= mode_d;
            cg_en_q    <= cg_en_d;
            err_q      <= err_d;
            in_valid_q <= in_valid_d;
            in_data_q  <= in_data_d;
            in_mode_q  <= in_mode_d;
            tx_buf_q   <= tx_buf_d;
            rx_buf_q   <= rx_buf_d;
`ifdef SP_HOST_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign err      = err_q;
    assign cg_en    = cg_en_q;
    assign in_valid = in_valid_q;
    assign in_data  = in_data_q;
    assign in_mode  = in_mode_q;
    assign rd_data  = (rd_addr < 4'(DEPTH)) ? rx_buf_q[rd_addr] : 9'd0;

endmodule

// File: tb/tb_sp_host.sv
// tb/tb_sp_host.sv - self-checking bench for sp_host (DEPTH=6, TIMEOUT=20)

module tb_sp_host;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld_valid;
    logic [8:0] ld_data;
    logic       start;
    logic [2:0] start_mode;
    logic       start_cg;
    logic       busy, done, err;
    logic [3:0] rd_addr;
    logic [8:0] rd_data;
    logic       cg_en, in_valid;
    logic [8:0] in_data;
    logic [2:0] in_mode;
    logic       out_valid;
    logic [8:0] out_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sp_host #(.DEPTH(6), .TIMEOUT(20)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_data(ld_data),
        .start(start), .start_mode(start_mode), .start_cg(start_cg),
        .busy(busy), .done(done), .err(err),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .cg_en(cg_en), .in_valid(in_valid), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_data(out_data)
    );

    typedef struct packed {
        logic [3:0]      n_load;   // samples loaded, values 1..n_load
        logic            co;       // last load in same cycle as start
        logic [2:0]      mode;
        logic            cg;
        logic [3:0]      n_resp;   // response beats
        logic [8:0]      base;     // response values base..base+n_resp-1
        logic            ov;       // out_valid pulse during beat 2
        logic [5:0][8:0] exp;      // expected burst, exp[0] first
        logic            exp_err;
    } frame_t;

    typedef struct packed {
        logic [3:0] addr;
        logic [8:0] exp;
    } rd_vec_t;

    frame_t  frames [4];
    rd_vec_t rd_vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_and_start(input frame_t f);
        for (int k = 1; k <= int'(f.n_load); k++) begin
            ld_valid = 1'b1;
            ld_data  = 9'(k);
            if (f.co && k == int'(f.n_load)) begin
                start = 1'b1; start_mode = f.mode; start_cg = f.cg;
            end
            step();
        end
        ld_valid = 1'b0;
        if (!f.co) begin
            start = 1'b1; start_mode = f.mode; start_cg = f.cg;
            step();
        end
        start = 1'b0;
    endtask

    task automatic run_frame(input int idx, input frame_t f);
        load_and_start(f);
        for (int i = 0; i < 6; i++) begin
            out_valid = (f.ov && i == 2);
            out_data  = 9'h1ff;
            @(negedge clk);
            chk($sformatf("f%0d beat%0d in_valid", idx, i), int'(in_valid), 1);
            chk($sformatf("f%0d beat%0d in_data", idx, i), int'(in_data), int'(f.exp[i]));
            chk($sformatf("f%0d beat%0d in_mode", idx, i), int'(in_mode), (i == 0) ? int'(f.mode) : 0);
            if (i == 0) begin
                chk($sformatf("f%0d busy", idx), int'(busy), 1);
                chk($sformatf("f%0d cg_en", idx), int'(cg_en), int'(f.cg));
                chk($sformatf("f%0d err cleared", idx), int'(err), 0);
            end
            step();
        end
        out_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("f%0d wait in_valid", idx), int'(in_valid), 0);
        step();
        for (int j = 0; j < int'(f.n_resp); j++) begin
            out_valid = 1'b1;
            out_data  = f.base + 9'(j);
            step();
        end
        out_valid = 1'b0;
        if (int'(f.n_resp) < 6) begin
            @(negedge clk);
            chk($sformatf("f%0d done early", idx), int'(done), 0);
            step();
        end
        @(negedge clk);
        chk($sformatf("f%0d done", idx), int'(done), 1);
        chk($sformatf("f%0d err", idx), int'(err), int'(f.exp_err));
        for (int j = 0; j < int'(f.n_resp); j++) begin
            rd_addr = 4'(j);
            #1;
            chk($sformatf("f%0d rd_data[%0d]", idx, j), int'(rd_data), int'(f.base) + j);
        end
        step();
        @(negedge clk);
        chk($sformatf("f%0d done pulse end", idx), int'(done), 0);
        chk($sformatf("f%0d busy end", idx), int'(busy), 0);
        step();
    endtask

    initial begin
        bit saw_busy_low, saw_done;
        int done_at;

        frames[0] = '{n_load: 4'd6, co: 1'b0, mode: 3'd3, cg: 1'b1, n_resp: 4'd6,
                      base: 9'd10, ov: 1'b0,
                      exp: {9'd6, 9'd5, 9'd4, 9'd3, 9'd2, 9'd1}, exp_err: 1'b0};
        frames[1] = '{n_load: 4'd8, co: 1'b1, mode: 3'd5, cg: 1'b0, n_resp: 4'd6,
                      base: 9'd20, ov: 1'b0,
                      exp: {9'd6, 9'd5, 9'd4, 9'd3, 9'd8, 9'd7}, exp_err: 1'b0};
        frames[2] = '{n_load: 4'd6, co: 1'b0, mode: 3'd1, cg: 1'b1, n_resp: 4'd4,
                      base: 9'd40, ov: 1'b0,
                      exp: {9'd6, 9'd5, 9'd4, 9'd3, 9'd2, 9'd1}, exp_err: 1'b1};
        frames[3] = '{n_load: 4'd6, co: 1'b0, mode: 3'd7, cg: 1'b0, n_resp: 4'd6,
                      base: 9'd50, ov: 1'b1,
                      exp: {9'd6, 9'd5, 9'd4, 9'd3, 9'd2, 9'd1}, exp_err: 1'b1};

        rd_vecs[0] = '{addr: 4'd0,  exp: 9'd10};
        rd_vecs[1] = '{addr: 4'd1,  exp: 9'd11};
        rd_vecs[2] = '{addr: 4'd2,  exp: 9'd12};
        rd_vecs[3] = '{addr: 4'd3,  exp: 9'd13};
        rd_vecs[4] = '{addr: 4'd4,  exp: 9'd14};
        rd_vecs[5] = '{addr: 4'd5,  exp: 9'd15};
        rd_vecs[6] = '{addr: 4'd6,  exp: 9'd0};
        rd_vecs[7] = '{addr: 4'd15, exp: 9'd0};

        rst = 1'b1; ld_valid = 1'b0; ld_data = '0; start = 1'b0;
        start_mode = '0; start_cg = 1'b0; rd_addr = '0;
        out_valid = 1'b0; out_data = '0;
        #1;
        chk("reset in_valid", int'(in_valid), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset err", int'(err), 0);
        chk("reset cg_en", int'(cg_en), 0);
        chk("reset rd_data", int'(rd_data), 0);
        step(); step();
        rst = 1'b0;
        step();

        for (int f = 0; f < 4; f++) begin
            run_frame(f, frames[f]);
            if (f == 0) begin
                for (int v = 0; v < 8; v++) begin
                    rd_addr = rd_vecs[v].addr;
                    #1;
                    chk($sformatf("rd table addr %0d", rd_vecs[v].addr),
                        int'(rd_data), int'(rd_vecs[v].exp));
                end
            end
        end

        // Reset asserted mid-SEND aborts the frame immediately.
        load_and_start(frames[0]);
        step(); step();
        #2;
        rst = 1'b1;
        #1;
        rd_addr = 4'd0;
        #1;
        chk("midrst in_valid", int'(in_valid), 0);
        chk("midrst in_data", int'(in_data), 0);
        chk("midrst in_mode", int'(in_mode), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst cg_en", int'(cg_en), 0);
        chk("midrst err", int'(err), 0);
        chk("midrst rd_data", int'(rd_data), 0);
        saw_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("midrst no done", int'(saw_done), 0);
        step();
        rst = 1'b0;
        step();

        // No response: timeout build finishes after 20 WAIT cycles, otherwise WAIT holds.
        load_and_start(frames[0]);
        for (int i = 0; i < 6; i++) step();
`ifdef SP_HOST_TIMEOUT_EN
        done_at = -1;
        for (int k = 0; k < 40 && done_at < 0; k++) begin
            @(negedge clk);
            if (done) done_at = k;
            step();
        end
        chk("timeout done cycle", done_at, 20);
        chk("timeout err", int'(err), 1);
`else
        done_at = 0;
        saw_busy_low = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 220; k++) begin
            @(negedge clk);
            if (!busy) saw_busy_low = 1'b1;
            if (done) saw_done = 1'b1;
            step();
        end
        chk("hold busy", int'(saw_busy_low), 0);
        chk("hold no done", int'(saw_done), 0);
        chk("hold done_at", done_at, 0);
        rst = 1'b1;
        #1;
        chk("hold reset busy", int'(busy), 0);
        step();
        rst = 1'b0;
`endif
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
